// File: rtl/rescale_sequencer.sv
// Two-pass frame controller: pass 1 streams the frame into xtremeSearch for min/max,
// pass 2 re-reads it into the rescaler with the latched offset and range.
module rescale_sequencer #(
  parameter int NB_PIXEL = 19,
  parameter int NB_COUNT = 32,
  parameter int NB_ADDR  = 19,
  parameter int TIMEOUT  = 1024
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                i_start,
  input  logic                i_abort,
  input  logic [NB_COUNT-1:0] i_imageSize,
  output logic                o_rdEn,
  output logic [NB_ADDR-1:0]  o_rdAddr,
  input  logic [NB_PIXEL-1:0] i_rdData,
  output logic                o_srchReset,
  output logic                o_srchValid,
  output logic [NB_PIXEL-1:0] o_srchValue,
  input  logic                i_srchEnd,
  input  logic [NB_PIXEL-1:0] i_maxValue,
  input  logic [NB_PIXEL-1:0] i_minValue,
  input  logic                i_scaleReady,
  output logic                o_scaleValid,
  output logic [NB_PIXEL-1:0] o_scaleValue,
  output logic [NB_PIXEL-1:0] o_offset,
  output logic [NB_PIXEL:0]   o_range,
  output logic                o_flat,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_error
);

  localparam int NB_TMO = $clog2(TIMEOUT + 1);

  localparam logic [3:0] StIdle    = 4'd0;
  localparam logic [3:0] StClear   = 4'd1;
  localparam logic [3:0] StSearch  = 4'd2;
  localparam logic [3:0] StWaitEnd = 4'd3;
  localparam logic [3:0] StLatch   = 4'd4;
  localparam logic [3:0] StRescale = 4'd5;
  localparam logic [3:0] StDrain   = 4'd6;
  localparam logic [3:0] StDone    = 4'd7;
  localparam logic [3:0] StError   = 4'd8;

  logic [3:0]          stateQ, stateD;
  logic [NB_ADDR-1:0]  addrQ, addrD;
  logic [NB_ADDR-1:0]  lastQ, lastD;
  logic [NB_TMO-1:0]   tmoQ, tmoD;
  logic                srchValidQ, scaleValidQ;
  logic [NB_PIXEL-1:0] offsetQ;
  logic [NB_PIXEL:0]   rangeQ;
  logic                flatQ;

  logic rdEn, srchReset, done, error, latch;
  logic sizeZero, sizeTooBig, passOne, passTwo;
  logic [NB_PIXEL:0] rangeCalc;

  assign sizeZero   = (i_imageSize == '0);
  assign sizeTooBig = |i_imageSize[NB_COUNT-1:NB_ADDR];
  assign passOne    = (stateQ == StSearch);
  assign passTwo    = (stateQ == StRescale);
  // Sign-extend both operands so max-min never overflows.
  assign rangeCalc  = {i_maxValue[NB_PIXEL-1], i_maxValue} - {i_minValue[NB_PIXEL-1], i_minValue};

  always_comb begin
    stateD    = stateQ;
    addrD     = addrQ;
    lastD     = lastQ;
    tmoD      = tmoQ;
    rdEn      = 1'b0;
    srchReset = 1'b0;
    done      = 1'b0;
    error     = 1'b0;
    latch     = 1'b0;
    case (stateQ)
      StIdle: begin
        addrD = '0;
        if (i_start) begin
          lastD  = i_imageSize[NB_ADDR-1:0] - 1'b1;
          stateD = (sizeZero || sizeTooBig) ? StError : StClear;
        end
      end
      StClear: begin
        srchReset = 1'b1;
        addrD     = '0;
        stateD    = StSearch;
      end
      StSearch: begin
        rdEn = 1'b1;
        tmoD = '0;
        if (addrQ == lastQ) begin
          addrD  = '0;
          stateD = StWaitEnd;
        end else begin
          addrD = addrQ + 1'b1;
        end
      end
      StWaitEnd: begin
        tmoD = tmoQ + 1'b1;
        // The final beat is still in flight on the first cycle; the end flag is not trusted yet.
        if (!srchValidQ && i_srchEnd) begin
          stateD = StLatch;
        end else if (tmoQ == NB_TMO'(TIMEOUT - 1)) begin
          stateD = StError;
        end
      end
      StLatch: begin
        latch  = 1'b1;
        addrD  = '0;
        stateD = StRescale;
      end
      StRescale: begin
        rdEn = i_scaleReady;
        if (i_scaleReady) begin
          if (addrQ == lastQ) begin
            addrD  = '0;
            stateD = StDrain;
          end else begin
            addrD = addrQ + 1'b1;
          end
        end
      end
      StDrain: stateD = StDone;
      StDone: begin
        done   = 1'b1;
        stateD = StIdle;
      end
      StError: begin
        error  = 1'b1;
        stateD = StIdle;
      end
      default: stateD = StIdle;
    endcase
    if (i_abort) begin
      stateD = StIdle;
      addrD  = '0;
      latch  = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stateQ      <= StIdle;
      addrQ       <= '0;
      lastQ       <= '0;
      tmoQ        <= '0;
      srchValidQ  <= 1'b0;
      scaleValidQ <= 1'b0;
      offsetQ     <= '0;
      rangeQ      <= '0;
      flatQ       <= 1'b0;
    end else begin
      stateQ      <= stateD;
      addrQ       <= addrD;
      lastQ       <= lastD;
      tmoQ        <= tmoD;
      srchValidQ  <= rdEn & passOne;
      scaleValidQ <= rdEn & passTwo;
      if (latch) begin
        offsetQ <= i_minValue;
        rangeQ  <= rangeCalc;
        flatQ   <= (rangeCalc == '0);
      end
    end
  end

  assign o_rdEn       = rdEn;
  assign o_rdAddr     = rdEn ? addrQ : '0;
  assign o_srchReset  = srchReset;
  assign o_srchValid  = srchValidQ;
  assign o_srchValue  = srchValidQ ? i_rdData : '0;
  assign o_scaleValid = scaleValidQ;
  assign o_scaleValue = scaleValidQ ? i_rdData : '0;
  assign o_offset     = offsetQ;
  assign o_range      = rangeQ;
  assign o_flat       = flatQ;
  assign o_busy       = (stateQ != StIdle);
  assign o_done       = done;
  assign o_error      = error;

endmodule

// File: tb/tb_rescale_sequencer.sv
// Randomized bench for rescale_sequencer with behavioural frame buffer, searcher and rescaler.
module tb_rescale_sequencer;

  localparam int TIMEOUT = 1024;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        i_start = 1'b0;
  logic        i_abort = 1'b0;
  logic [31:0] i_imageSize = '0;
  logic        o_rdEn;
  logic [18:0] o_rdAddr;
  logic [18:0] i_rdData = '0;
  logic        o_srchReset, o_srchValid;
  logic [18:0] o_srchValue;
  logic        i_srchEnd = 1'b0;
  logic [18:0] i_maxValue = '0, i_minValue = '0;
  logic        i_scaleReady = 1'b1;
  logic        o_scaleValid;
  logic [18:0] o_scaleValue, o_offset;
  logic [19:0] o_range;
  logic        o_flat, o_busy, o_done, o_error;

  rescale_sequencer #(.TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .i_start(i_start), .i_abort(i_abort),
    .i_imageSize(i_imageSize), .o_rdEn(o_rdEn), .o_rdAddr(o_rdAddr), .i_rdData(i_rdData),
    .o_srchReset(o_srchReset), .o_srchValid(o_srchValid), .o_srchValue(o_srchValue),
    .i_srchEnd(i_srchEnd), .i_maxValue(i_maxValue), .i_minValue(i_minValue),
    .i_scaleReady(i_scaleReady), .o_scaleValid(o_scaleValid), .o_scaleValue(o_scaleValue),
    .o_offset(o_offset), .o_range(o_range), .o_flat(o_flat), .o_busy(o_busy),
    .o_done(o_done), .o_error(o_error)
  );

  always #5 clock = ~clock;

  logic signed [18:0] mem [0:1023];
  int vectors = 0, misses = 0;
  int cyc = 0, rdEnCnt, busyCnt, doneCnt, errCnt, srchResetCnt, srchBeats, scaleBeats;
  int srchIdx = 0, scaleIdx = 0, lastRdCyc = 0, errCyc = 0;
  int runMin = 0, runMax = 0, curN = 0, readyMode = 0;
  bit srchEndEn = 1'b1;
  logic readyPrev = 1'b1;
  longint expOff = 0, expRange = 0, expFlat = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    vectors++;
    if (got !== exp) begin
      misses++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  // Frame buffer: one-cycle read latency.
  always @(posedge clock) if (o_rdEn && o_rdAddr < 19'd1024) i_rdData <= mem[o_rdAddr[9:0]];

  // Observers, xtremeSearch model and rescaler ready driver.
  always @(negedge clock) begin
    cyc++;
    if (o_rdEn) begin rdEnCnt++; lastRdCyc = cyc; end
    if (o_busy) busyCnt++;
    if (o_done) doneCnt++;
    if (o_error) begin errCnt++; errCyc = cyc; end
    if (o_srchReset) begin
      srchResetCnt++;
      srchIdx = 0;
      runMin = 1 << 30;
      runMax = -(1 << 30);
    end
    if (o_srchValid) begin
      check("srchBeat", $signed(o_srchValue), mem[srchIdx % 1024]);
      if (int'(mem[srchIdx % 1024]) < runMin) runMin = int'(mem[srchIdx % 1024]);
      if (int'(mem[srchIdx % 1024]) > runMax) runMax = int'(mem[srchIdx % 1024]);
      srchIdx++;
      srchBeats++;
    end
    if (o_scaleValid) begin
      check("scaleBeat", $signed(o_scaleValue), mem[scaleIdx % 1024]);
      check("beatReady", readyPrev, 1);
      scaleIdx++;
      scaleBeats++;
    end
    i_minValue = runMin[18:0];
    i_maxValue = runMax[18:0];
    i_srchEnd  = srchEndEn && curN > 0 && srchIdx == curN;
    case (readyMode)
      0:       i_scaleReady = 1'b1;
      1:       i_scaleReady = ~i_scaleReady;
      default: i_scaleReady = 1'($urandom_range(1));
    endcase
    readyPrev = i_scaleReady;
  end

  task automatic clearCounts();
    rdEnCnt = 0; busyCnt = 0; doneCnt = 0; errCnt = 0; srchResetCnt = 0;
    srchBeats = 0; scaleBeats = 0; scaleIdx = 0;
  endtask

  task automatic fillRandom(input int n, input int lo, input int hi);
    for (int i = 0; i < n; i++) mem[i] = 19'(int'($urandom_range(hi - lo)) + lo);
  endtask

  task automatic startPulse(input int n);
    i_start = 1'b1; i_imageSize = 32'(n);
    tick();
    i_start = 1'b0;
  endtask

  task automatic runFrame(input int n, input int mode, input bit endEn);
    bit valid, ok;
    int lo, hi, bound;
    valid = (n > 0) && (n < (1 << 19));
    ok = valid && endEn;
    curN = n; readyMode = mode; srchEndEn = endEn;
    clearCounts();
    startPulse(n);
    if (valid) begin
      repeat (3) tick();
      startPulse(3);  // must be ignored while busy
      i_imageSize = 32'(n);
    end
    bound = 4 * n + TIMEOUT + 50;
    for (int i = 0; i < bound && doneCnt + errCnt == 0; i++) tick();
    repeat (3) tick();
    check("finished", (doneCnt + errCnt > 0) ? 1 : 0, 1);
    if (ok) begin
      lo = 1 << 30; hi = -(1 << 30);
      for (int i = 0; i < n; i++) begin
        if (int'(mem[i]) < lo) lo = int'(mem[i]);
        if (int'(mem[i]) > hi) hi = int'(mem[i]);
      end
      expOff = lo; expRange = hi - lo; expFlat = (hi == lo) ? 1 : 0;
    end
    check("doneCnt", doneCnt, ok ? 1 : 0);
    check("errCnt", errCnt, ok ? 0 : 1);
    check("srchBeats", srchBeats, valid ? n : 0);
    check("scaleBeats", scaleBeats, ok ? n : 0);
    check("srchReset", srchResetCnt, valid ? 1 : 0);
    check("offset", $signed(o_offset), expOff);
    check("range", o_range, expRange);
    check("flat", o_flat, expFlat);
    check("idleBusy", o_busy, 0);
    if (!valid) begin
      check("errNoRead", rdEnCnt, 0);
      check("errBusyCycles", busyCnt, 1);
    end
    if (valid && !endEn) check("timeoutCycles", errCyc - lastRdCyc, TIMEOUT + 1);
  endtask

  task automatic waitAddr40();
    int i;
    i = 0;
    while (!(o_rdEn && o_rdAddr == 19'd40) && i < 300) begin tick(); i++; end
    check("reachAddr40", i < 300 ? 1 : 0, 1);
  endtask

  initial begin
    #1;
    check("rstOutsA", |{o_rdEn, o_rdAddr, o_srchReset, o_srchValid, o_srchValue, o_busy}, 0);
    check("rstOutsB", |{o_scaleValid, o_scaleValue, o_offset, o_range, o_flat, o_done, o_error}, 0);
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Known frame: ramp with a single -1.
    for (int i = 0; i < 100; i++) mem[i] = 19'(i);
    mem[3] = -19'sd1;
    runFrame(100, 0, 1'b1);
    check("t1Offset", $signed(o_offset), -1);
    check("t1Range", o_range, 100);

    runFrame(0, 0, 1'b1);
    for (int i = 0; i < 16; i++) mem[i] = 19'sd7;
    runFrame(16, 2, 1'b1);
    check("t3Flat", o_flat, 1);
    fillRandom(20, -1000, 1000);
    runFrame(20, 1, 1'b1);
    fillRandom(5, -50, 50);
    runFrame(5, 0, 1'b0);
    runFrame(1 << 19, 0, 1'b1);
    fillRandom(1, -(1 << 18), (1 << 18) - 1);
    runFrame(1, 2, 1'b1);
    mem[0] = -19'sd262144; mem[1] = 19'sd262143;
    runFrame(2, 0, 1'b1);
    check("extremeRange", o_range, 524287);

    // Async reset mid-pass.
    fillRandom(100, -5000, 5000);
    curN = 100; readyMode = 0; srchEndEn = 1'b1; clearCounts();
    startPulse(100);
    waitAddr40();
    reset = 1'b1;
    #1;
    check("midRstA", |{o_rdEn, o_rdAddr, o_srchReset, o_srchValid, o_srchValue, o_busy}, 0);
    check("midRstB", |{o_scaleValid, o_scaleValue, o_offset, o_range, o_flat, o_done, o_error}, 0);
    tick();
    reset = 1'b0;
    expOff = 0; expRange = 0; expFlat = 0;
    tick();
    fillRandom(50, -3000, 3000);
    runFrame(50, 2, 1'b1);

    // Abort mid-pass: reads stop next cycle, in-flight beat still delivered.
    fillRandom(100, -700, 700);
    curN = 100; clearCounts();
    startPulse(100);
    waitAddr40();
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    check("abortBusy", o_busy, 0);
    check("abortRdEn", o_rdEn, 0);
    check("abortInflight", o_srchValid, 1);
    repeat (4) tick();
    check("abortNoDone", doneCnt + errCnt, 0);
    runFrame(100, 2, 1'b1);

    for (int k = 0; k < 3; k++) begin
      int n;
      n = int'($urandom_range(1, 60));
      fillRandom(n, -(1 << 18), (1 << 18) - 1);
      runFrame(n, 2, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule
